// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uarttx transmitter between NREQ byte producers.
// A granted requester keeps the transmitter until it presents a byte marked last.
module uart_tx_arbiter #(
    parameter int NREQ     = 4,
    parameter int START_TO = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [NREQ-1:0]   i_req,
    input  logic [8*NREQ-1:0] i_data,
    input  logic [NREQ-1:0]   i_last,
    output logic [NREQ-1:0]   o_ack,
    output logic [NREQ-1:0]   o_grant,
    input  logic              i_idle,
    output logic              o_wrsig,
    output logic [7:0]        o_dataout,
    output logic              o_busy,
    output logic              o_timeout_err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(START_TO + 1);

    localparam logic [1:0] ARB     = 2'd0;
    localparam logic [1:0] SEND    = 2'd1;
    localparam logic [1:0] WAIT_LO = 2'd2;
    localparam logic [1:0] WAIT_HI = 2'd3;

    logic [1:0]      r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic            r_locked;
    logic [NREQ-1:0] r_grant;
    logic [7:0]      r_dataout;
    logic            r_last_q;
    logic [CW-1:0]   r_cnt;
    logic            r_timeout;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_idx;
    logic [7:0]      w_win_data;
    logic            w_win_last;
    logic [NREQ-1:0] w_onehot;

    function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] idx);
        if (idx == PW'(NREQ - 1))
            return '0;
        else
            return idx + PW'(1);
    endfunction

    // Winner scan: locked owner only, otherwise first request at or after r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_sum   = '0;
        w_idx   = '0;
        if (r_locked) begin
            w_found = i_req[r_owner];
            w_win   = r_owner;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NREQ))
                    w_sum = w_sum - (PW+1)'(NREQ);
                w_idx = w_sum[PW-1:0];
                if (!w_found && i_req[w_idx]) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                end
            end
        end
    end

    always_comb begin
        w_win_data = '0;
        w_win_last = 1'b0;
        w_onehot   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == PW'(i)) begin
                w_win_data  = i_data[8*i +: 8];
                w_win_last  = i_last[i];
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state   <= ARB;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_locked  <= 1'b0;
            r_grant   <= '0;
            r_dataout <= '0;
            r_last_q  <= 1'b0;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                ARB: begin
                    if (i_idle && w_found) begin
                        r_grant   <= w_onehot;
                        r_owner   <= w_win;
                        r_dataout <= w_win_data;
                        r_last_q  <= w_win_last;
                        r_state   <= SEND;
                    end
                end
                SEND: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_LO;
                end
                WAIT_LO: begin
                    if (!i_idle) begin
                        r_state <= WAIT_HI;
                    end else if (r_cnt == CW'(START_TO - 1)) begin
                        // Transmitter never started: drop the byte and release the owner.
                        r_timeout <= 1'b1;
                        r_locked  <= 1'b0;
                        r_grant   <= '0;
                        r_ptr     <= f_next_ptr(r_owner);
                        r_state   <= ARB;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                WAIT_HI: begin
                    if (i_idle) begin
                        if (r_last_q) begin
                            r_locked <= 1'b0;
                            r_grant  <= '0;
                            r_ptr    <= f_next_ptr(r_owner);
                        end else begin
                            r_locked <= 1'b1;
                        end
                        r_state <= ARB;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign o_wrsig       = (r_state == SEND);
    assign o_ack         = r_grant & {NREQ{o_wrsig}};
    assign o_grant       = r_grant;
    assign o_dataout     = r_dataout;
    assign o_busy        = (r_state != ARB);
    assign o_timeout_err = r_timeout;

endmodule
